// File: rtl/screensaver_motion_ctrl.sv
// screensaver_motion_ctrl: per-frame position/bounce/palette scheduler for the
// bouncing-logo screensaver. Once per accepted frame_start, walks
// IDLE -> CALC_X -> CALC_Y -> COMMIT and publishes pos_x/pos_y/color_idx together.
// Optional build macro SCREENSAVER_CORNER_COUNT_EN enables the saturating
// corner_count register; without it corner_count is a constant zero.
module screensaver_motion_ctrl #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned SPRITE_W     = 64,
  parameter int unsigned SPRITE_H     = 32,
  parameter int unsigned X_INIT       = 100,
  parameter int unsigned Y_INIT       = 50,
  parameter int unsigned PALETTE_SIZE = 6
) (
  input  logic       clk_25_175,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       pause,
  input  logic [1:0] speed,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [2:0] color_idx,
  output logic       bounce,
  output logic       corner,
  output logic       busy,
  output logic       overrun,
  output logic [7:0] corner_count
);

  localparam int unsigned X_MAX = H_ACTIVE - SPRITE_W;
  localparam int unsigned Y_MAX = V_ACTIVE - SPRITE_H;
  localparam logic [10:0] X_MAX_W  = 11'(X_MAX);
  localparam logic [10:0] Y_MAX_W  = 11'(Y_MAX);
  localparam logic [2:0]  COLOR_LAST = 3'(PALETTE_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC_X = 2'd1,
    CALC_Y = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t      state;
  logic [2:0]  step;
  logic        dir_x;   // 1 = moving right
  logic        dir_y;   // 1 = moving down
  logic [9:0]  nx;
  logic [9:0]  ny;
  logic        ndir_x;
  logic        ndir_y;
  logic        hit_x;
  logic        hit_y;

  // 11-bit forward/backward candidates so edge tests can never wrap
  logic [10:0] x_fwd_c;
  logic [10:0] x_back_c;
  logic [10:0] y_fwd_c;
  logic [10:0] y_back_c;
  logic [10:0] step_w_c;

  assign step_w_c = 11'(step);
  assign x_fwd_c  = 11'(pos_x) + step_w_c;
  assign x_back_c = 11'(pos_x) - step_w_c;
  assign y_fwd_c  = 11'(pos_y) + step_w_c;
  assign y_back_c = 11'(pos_y) - step_w_c;

  // Motion FSM: shadow computation in CALC_X/CALC_Y, atomic publish in COMMIT
  always_ff @(posedge clk_25_175 or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      step      <= 3'd1;
      pos_x     <= 10'(X_INIT);
      pos_y     <= 10'(Y_INIT);
      color_idx <= 3'd0;
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      nx        <= 10'(X_INIT);
      ny        <= 10'(Y_INIT);
      ndir_x    <= 1'b1;
      ndir_y    <= 1'b1;
      hit_x     <= 1'b0;
      hit_y     <= 1'b0;
      bounce    <= 1'b0;
      corner    <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
`ifdef SCREENSAVER_CORNER_COUNT_EN
      corner_count <= 8'd0;
`endif
    end else begin
      bounce <= 1'b0;
      corner <= 1'b0;

      // A frame_start that lands on an in-flight update is dropped and flagged
      if (frame_start && (state != IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (frame_start && !pause) begin
            step  <= 3'(speed) + 3'd1;
            busy  <= 1'b1;
            state <= CALC_X;
          end
        end

        CALC_X: begin
          if (dir_x) begin
            if (x_fwd_c >= X_MAX_W) begin
              nx     <= 10'(X_MAX);
              ndir_x <= 1'b0;
              hit_x  <= 1'b1;
            end else begin
              nx     <= x_fwd_c[9:0];
              ndir_x <= 1'b1;
              hit_x  <= 1'b0;
            end
          end else begin
            if (11'(pos_x) <= step_w_c) begin
              nx     <= 10'd0;
              ndir_x <= 1'b1;
              hit_x  <= 1'b1;
            end else begin
              nx     <= x_back_c[9:0];
              ndir_x <= 1'b0;
              hit_x  <= 1'b0;
            end
          end
          state <= CALC_Y;
        end

        CALC_Y: begin
          if (dir_y) begin
            if (y_fwd_c >= Y_MAX_W) begin
              ny     <= 10'(Y_MAX);
              ndir_y <= 1'b0;
              hit_y  <= 1'b1;
            end else begin
              ny     <= y_fwd_c[9:0];
              ndir_y <= 1'b1;
              hit_y  <= 1'b0;
            end
          end else begin
            if (11'(pos_y) <= step_w_c) begin
              ny     <= 10'd0;
              ndir_y <= 1'b1;
              hit_y  <= 1'b1;
            end else begin
              ny     <= y_back_c[9:0];
              ndir_y <= 1'b0;
              hit_y  <= 1'b0;
            end
          end
          state <= COMMIT;
        end

        COMMIT: begin
          pos_x  <= nx;
          pos_y  <= ny;
          dir_x  <= ndir_x;
          dir_y  <= ndir_y;
          bounce <= hit_x | hit_y;
          corner <= hit_x & hit_y;
          // One palette advance per frame, even when both edges are hit
          if (hit_x | hit_y) begin
            if (color_idx == COLOR_LAST) begin
              color_idx <= 3'd0;
            end else begin
              color_idx <= color_idx + 3'd1;
            end
          end
`ifdef SCREENSAVER_CORNER_COUNT_EN
          if (hit_x && hit_y && (corner_count != 8'hFF)) begin
            corner_count <= corner_count + 8'd1;
          end
`endif
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef SCREENSAVER_CORNER_COUNT_EN
  assign corner_count = 8'd0;
`endif

endmodule
